// File: rtl/sys_array_pkg.sv
// Shared types for the systolic-array tile scheduler: FSM states, tile descriptor and leaf marker.
package sys_array_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SPLIT,
        FETCH,
        CHECK,
        ISSUE,
        RUN,
        NEXT,
        FINISH
    } sched_state_t;

    typedef struct packed {
        logic [15:0] a_w0;
        logic [15:0] a_w1;
        logic [15:0] a_l0;
        logic [15:0] a_l1;
        logic [15:0] b_l0;
        logic [15:0] b_l1;
        logic [15:0] o_w0;
        logic [15:0] o_l0;
    } tile_desc_t;

    localparam logic [15:0] LEAF_MARK = 16'd0;

endpackage

// File: rtl/sys_array_tile_scheduler_if.sv
// Tile issue bus between the scheduler (master) and the systolic array controller (slave).
interface sys_array_tile_scheduler_if;
    import sys_array_pkg::*;

    logic       tile_valid;
    logic       tile_ready;
    tile_desc_t tile;
    logic       tile_accum;
    logic       array_done;

    modport master (
        output tile_valid, tile, tile_accum,
        input  tile_ready, array_done
    );

    modport slave (
        input  tile_valid, tile, tile_accum,
        output tile_ready, array_done
    );

endinterface

// File: rtl/sys_array_tile_scheduler.sv
// Walks the splitter node table and issues each leaf node as one tile job, waiting for array_done.
// Optional macro SYS_SCHED_ACCUM_EN: tile_accum flags K-split partial sums (a_l0 != 0).
module sys_array_tile_scheduler
    import sys_array_pkg::*;
#(
    parameter int MAX_NODES    = 100,
    parameter int DONE_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        split_ready,
    input  logic [15:0] split_last,
    output logic [15:0] tbl_idx,
    input  logic [15:0] tbl_a_w0,
    input  logic [15:0] tbl_a_w1,
    input  logic [15:0] tbl_a_l0,
    input  logic [15:0] tbl_a_l1,
    input  logic [15:0] tbl_b_l0,
    input  logic [15:0] tbl_b_l1,
    input  logic [15:0] tbl_o_w0,
    input  logic [15:0] tbl_o_l0,
    input  logic [15:0] tbl_to_n1,
    sys_array_tile_scheduler_if.master tile_if,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] tile_cnt
);

    localparam logic [15:0] MAX_IDX = 16'(MAX_NODES);
    localparam logic [15:0] TO_LIM  = 16'(DONE_TIMEOUT);

    sched_state_t state_q;
    logic [15:0]  idx_q;
    logic [15:0]  last_q;
    logic [15:0]  to_q;
    logic [15:0]  cnt_q;
    logic         busy_q;
    logic         done_q;
    logic         err_q;
    logic         valid_q;
    tile_desc_t   tile_q;
    logic [15:0]  idx_nxt;
    tile_desc_t   tbl_desc;
`ifdef SYS_SCHED_ACCUM_EN
    logic         accum_q;
`endif

    assign idx_nxt  = idx_q + 16'd1;
    assign tbl_desc = '{a_w0: tbl_a_w0, a_w1: tbl_a_w1, a_l0: tbl_a_l0, a_l1: tbl_a_l1,
                        b_l0: tbl_b_l0, b_l1: tbl_b_l1, o_w0: tbl_o_w0, o_l0: tbl_o_l0};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            to_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            tile_q  <= '0;
`ifdef SYS_SCHED_ACCUM_EN
            accum_q <= 1'b0;
`endif
        end else if (start) begin
            // start always restarts, even mid-job; a pending descriptor is dropped here
            state_q <= WAIT_SPLIT;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: ;
                WAIT_SPLIT: begin
                    if (split_ready) begin
                        last_q <= split_last;
                        if (split_last == 16'd0) begin
                            state_q <= FINISH;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= FETCH;
                        end
                    end
                end
                FETCH: state_q <= CHECK;
                CHECK: begin
                    if (tbl_to_n1 != LEAF_MARK) begin
                        state_q <= NEXT;
                    end else begin
                        tile_q  <= tbl_desc;
                        valid_q <= 1'b1;
`ifdef SYS_SCHED_ACCUM_EN
                        accum_q <= (tbl_a_l0 != 16'd0);
`endif
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (tile_if.tile_ready) begin
                        valid_q <= 1'b0;
                        to_q    <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (tile_if.array_done) begin
                        cnt_q   <= cnt_q + 16'd1;
                        state_q <= NEXT;
                    end else if (DONE_TIMEOUT != 0 && (to_q + 16'd1) == TO_LIM) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= FINISH;
                    end else begin
                        to_q <= to_q + 16'd1;
                    end
                end
                NEXT: begin
                    // idx is never advanced onto MAX_NODES or past the last valid node
                    if (idx_nxt == last_q || idx_nxt == MAX_IDX) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= FINISH;
                    end else begin
                        idx_q   <= idx_nxt;
                        state_q <= FETCH;
                    end
                end
                FINISH: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tbl_idx            = idx_q;
    assign tile_if.tile_valid = valid_q;
    assign tile_if.tile       = tile_q;
`ifdef SYS_SCHED_ACCUM_EN
    assign tile_if.tile_accum = accum_q;
`else
    assign tile_if.tile_accum = 1'b0;
`endif
    assign busy               = busy_q;
    assign done               = done_q;
    assign error              = err_q;
    assign tile_cnt           = cnt_q;

endmodule

// File: tb/tb_sys_array_tile_scheduler.sv
// Directed bench for sys_array_tile_scheduler with a registered (1-cycle latency) node table model.
module tb_sys_array_tile_scheduler;
    import sys_array_pkg::*;

`ifdef SYS_SCHED_ACCUM_EN
    localparam logic ACC_EN = 1'b1;
`else
    localparam logic ACC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        split_ready = 1'b0;
    logic [15:0] split_last = '0;
    logic [15:0] tbl_idx;
    logic [15:0] tbl_to_n1;
    logic        busy, done, error;
    logic [15:0] tile_cnt;

    tile_desc_t  mem_desc [8];
    logic [15:0] mem_n1   [8];
    tile_desc_t  rd_desc;
    logic [15:0] rd_n1;

    int n_assert = 0;
    int n_fail   = 0;

    sys_array_tile_scheduler_if tif();

    sys_array_tile_scheduler #(.MAX_NODES(100), .DONE_TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .split_ready(split_ready), .split_last(split_last), .tbl_idx(tbl_idx),
        .tbl_a_w0(rd_desc.a_w0), .tbl_a_w1(rd_desc.a_w1), .tbl_a_l0(rd_desc.a_l0),
        .tbl_a_l1(rd_desc.a_l1), .tbl_b_l0(rd_desc.b_l0), .tbl_b_l1(rd_desc.b_l1),
        .tbl_o_w0(rd_desc.o_w0), .tbl_o_l0(rd_desc.o_l0), .tbl_to_n1(tbl_to_n1),
        .tile_if(tif.master),
        .busy(busy), .done(done), .error(error), .tile_cnt(tile_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_desc <= mem_desc[tbl_idx[2:0]];
        rd_n1   <= mem_n1[tbl_idx[2:0]];
    end
    assign tbl_to_n1 = rd_n1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_table();
        for (int i = 0; i < 8; i++) begin
            mem_desc[i] = '0;
            mem_n1[i]   = 16'd0;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_done();
        tif.array_done = 1'b1;
        tick();
        tif.array_done = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (tif.tile_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid_seen"}, tif.tile_valid, 1'b1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, done, 1'b1);
        check({tag, "_busy_off"}, busy, 1'b0);
    endtask

    task automatic check_idle(input string p);
        check({p, "_idx"}, tbl_idx, 16'd0);
        check({p, "_valid"}, tif.tile_valid, 1'b0);
        check({p, "_tile"}, tif.tile, 128'd0);
        check({p, "_accum"}, tif.tile_accum, 1'b0);
        check({p, "_busy"}, busy, 1'b0);
        check({p, "_done"}, done, 1'b0);
        check({p, "_error"}, error, 1'b0);
        check({p, "_cnt"}, tile_cnt, 16'd0);
    endtask

    tile_desc_t exp_t;
    tile_desc_t n1_t, n2_t;

    initial begin
        tif.tile_ready = 1'b0;
        tif.array_done = 1'b0;
        clear_table();
        repeat (3) tick();
        check_idle("reset");
        reset_n = 1'b1;
        tick();

        // single leaf 3x3x3
        clear_table();
        mem_desc[0] = '{a_w0: 16'd0, a_w1: 16'd3, a_l0: 16'd0, a_l1: 16'd3,
                        b_l0: 16'd0, b_l1: 16'd3, o_w0: 16'd0, o_l0: 16'd0};
        split_last = 16'd1;
        split_ready = 1'b1;
        tif.tile_ready = 1'b1;
        pulse_start();
        check("t2_busy", busy, 1'b1);
        check("t2_cnt0", tile_cnt, 16'd0);
        wait_valid("t2");
        check("t2_tile", tif.tile, mem_desc[0]);
        check("t2_accum", tif.tile_accum, 1'b0);
        tick();
        check("t2_valid_drop", tif.tile_valid, 1'b0);
        pulse_done();
        check("t2_cnt1", tile_cnt, 16'd1);
        wait_done("t2");
        check("t2_cnt_final", tile_cnt, 16'd1);
        tick();
        check("t2_done_pulse", done, 1'b0);

        // root with two leaf children
        clear_table();
        mem_n1[0] = 16'd1;
        n1_t = '{a_w0: 16'd0, a_w1: 16'd1, a_l0: 16'd2, a_l1: 16'd3,
                 b_l0: 16'd4, b_l1: 16'd0, o_w0: 16'd0, o_l0: 16'd0};
        n2_t = '{a_w0: 16'd5, a_w1: 16'd6, a_l0: 16'd7, a_l1: 16'd8,
                 b_l0: 16'd9, b_l1: 16'd0, o_w0: 16'd0, o_l0: 16'd0};
        mem_desc[1] = n1_t;
        mem_desc[2] = n2_t;
        split_last = 16'd3;
        pulse_start();
        wait_valid("t3a");
        check("t3a_idx", tbl_idx, 16'd1);
        check("t3a_tile", tif.tile, n1_t);
        check("t3a_accum", tif.tile_accum, ACC_EN);
        tick();
        pulse_done();
        wait_valid("t3b");
        check("t3b_idx", tbl_idx, 16'd2);
        check("t3b_tile", tif.tile, n2_t);
        tick();
        pulse_done();
        wait_done("t3");
        check("t3_cnt", tile_cnt, 16'd2);

        // descriptor held while tile_ready stays low
        clear_table();
        exp_t = '{a_w0: 16'd1, a_w1: 16'd2, a_l0: 16'd5, a_l1: 16'd6,
                  b_l0: 16'd7, b_l1: 16'd8, o_w0: 16'd9, o_l0: 16'd10};
        mem_desc[0] = exp_t;
        split_last = 16'd1;
        tif.tile_ready = 1'b0;
        pulse_start();
        wait_valid("t4");
        check("t4_accum", tif.tile_accum, ACC_EN);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t4_hold_valid%0d", i), tif.tile_valid, 1'b1);
            check($sformatf("t4_hold_tile%0d", i), tif.tile, exp_t);
        end
        tif.tile_ready = 1'b1;
        tick();
        check("t4_valid_drop", tif.tile_valid, 1'b0);
        pulse_done();
        wait_done("t4");

        // timeout: array_done never arrives
        pulse_start();
        wait_valid("t5");
        tick();
        repeat (15) tick();
        check("t5_err_early", error, 1'b0);
        check("t5_done_early", done, 1'b0);
        tick();
        check("t5_err", error, 1'b1);
        check("t5_done", done, 1'b1);
        check("t5_busy", busy, 1'b0);
        tick();
        check("t5_done_pulse", done, 1'b0);
        check("t5_err_sticky", error, 1'b1);
        pulse_start();
        check("t5_err_clear", error, 1'b0);

        // start beats a coincident array_done, then reset in RUN
        clear_table();
        mem_n1[0] = 16'd1;
        mem_desc[1] = n1_t;
        mem_desc[2] = n2_t;
        split_last = 16'd3;
        pulse_start();
        wait_valid("t7a");
        tick();
        pulse_done();
        check("t7_cnt1", tile_cnt, 16'd1);
        wait_valid("t7b");
        tick();
        start = 1'b1;
        tif.array_done = 1'b1;
        tick();
        start = 1'b0;
        tif.array_done = 1'b0;
        check("t7_cnt_cleared", tile_cnt, 16'd0);
        check("t7_busy", busy, 1'b1);
        check("t7_idx", tbl_idx, 16'd0);
        wait_valid("t1");
        tick();
        check("t1_in_run_busy", busy, 1'b1);
        reset_n = 1'b0;
        tick();
        check_idle("t1_reset");
        reset_n = 1'b1;
        tick();
        check("t1_stays_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
